// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for a 16 x 16-bit program ROM.
// Keeps the program counter and presents one registered instruction to decode
// over a valid/ready handshake. Execute can redirect the PC. A halt request
// stops fetching until reset.
// Optional build macro FETCH_DEBUG_PORT_EN adds a debug reader that shares the
// single ROM read port with fetch. Debug is granted immediately when fetch has
// no use for the port. Otherwise it is granted after waiting three cycles.
module fetch_sequencer #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
`ifdef FETCH_DEBUG_PORT_EN
  ,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [INST_W-1:0] dbg_data,
  output logic              dbg_ack
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [INST_W-1:0]   inst_reg, inst_next;
  logic [ADDR_W-1:0]   inst_pc_reg, inst_pc_next;
  logic                inst_valid_reg, inst_valid_next;
  logic                halted_reg, halted_next;

  logic                fetch_need;
  logic                fetch_lost;   // debug holds the ROM port this cycle
  logic                accept;

`ifdef FETCH_DEBUG_PORT_EN
  logic [1:0]          starve_reg, starve_next;
  logic [INST_W-1:0]   dbg_data_reg, dbg_data_next;
  logic                dbg_ack_reg, dbg_ack_next;
`endif

  assign fetch_need = (state_reg == RUN) && (!inst_valid_reg || inst_ready);
  assign accept     = inst_valid_reg && inst_ready;

  // ROM port arbitration: debug wins when fetch is idle or debug has starved
`ifdef FETCH_DEBUG_PORT_EN
  assign fetch_lost = dbg_req && (!fetch_need || (starve_reg == 2'd3));
`else
  assign fetch_lost = 1'b0;
`endif

`ifdef FETCH_DEBUG_PORT_EN
  assign rom_addr = fetch_lost ? dbg_addr : pc_reg;
`else
  assign rom_addr = pc_reg;
`endif

  // Next-state logic: a redirect beats a capture, and a capture beats a plain accept
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    inst_valid_next = inst_valid_reg;
    if (state_reg == RUN) begin
      if (halt) begin
        state_next = HALT;
      end
      if (redirect_valid) begin
        pc_next         = redirect_pc;
        inst_valid_next = 1'b0;
      end else if (fetch_need && !fetch_lost && !halt) begin
        inst_next       = rom_data;
        inst_pc_next    = pc_reg;
        inst_valid_next = 1'b1;
        pc_next         = pc_reg + ADDR_W'(1);
      end else if (accept) begin
        inst_valid_next = 1'b0;
      end
    end else if (accept) begin
      // In HALT, only draining the held instruction is possible.
      inst_valid_next = 1'b0;
    end
    halted_next = (state_next == HALT) && !inst_valid_next;
  end

`ifdef FETCH_DEBUG_PORT_EN
  // Debug read side: count the cycles a request waits, and register the data on grant
  always_comb begin
    starve_next   = (dbg_req && !fetch_lost) ? starve_reg + 2'd1 : 2'd0;
    dbg_ack_next  = fetch_lost;
    dbg_data_next = fetch_lost ? rom_data : dbg_data_reg;
  end
`endif

  // State register for the fetch FSM, its outputs and the debug read path
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      pc_reg         <= '0;
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      inst_valid_reg <= 1'b0;
      halted_reg     <= 1'b0;
`ifdef FETCH_DEBUG_PORT_EN
      starve_reg     <= '0;
      dbg_data_reg   <= '0;
      dbg_ack_reg    <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      inst_reg       <= inst_next;
      inst_pc_reg    <= inst_pc_next;
      inst_valid_reg <= inst_valid_next;
      halted_reg     <= halted_next;
`ifdef FETCH_DEBUG_PORT_EN
      starve_reg     <= starve_next;
      dbg_data_reg   <= dbg_data_next;
      dbg_ack_reg    <= dbg_ack_next;
`endif
    end
  end

  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_valid = inst_valid_reg;
  assign halted     = halted_reg;
`ifdef FETCH_DEBUG_PORT_EN
  assign dbg_data   = dbg_data_reg;
  assign dbg_ack    = dbg_ack_reg;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks for each behaviour, followed by randomized
// traffic. Every output is compared each cycle against a cycle-level reference
// model, which is written from the fetch rules.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] inst;
  logic [3:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        halt;
  logic        halted;
`ifdef FETCH_DEBUG_PORT_EN
  logic        dbg_req = 1'b0;
  logic [3:0]  dbg_addr = 4'd0;
  logic [15:0] dbg_data;
  logic        dbg_ack;
`endif

  logic [15:0] rom [16];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_halt_st;
  logic [3:0]  m_pc;
  bit          m_valid;
  logic [15:0] m_inst;
  logic [3:0]  m_ipc;
  int          m_wait;
  logic [15:0] m_dbg_data;
  bit          m_dbg_ack;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_sequencer #(.ADDR_W(4), .INST_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
`ifdef FETCH_DEBUG_PORT_EN
    ,
    .dbg_req        (dbg_req),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data),
    .dbg_ack        (dbg_ack)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_halt_st  = 1'b0;
    m_pc       = 4'd0;
    m_valid    = 1'b0;
    m_inst     = 16'd0;
    m_ipc      = 4'd0;
    m_wait     = 0;
    m_dbg_data = 16'd0;
    m_dbg_ack  = 1'b0;
  endtask

  function automatic bit model_dbg_owns(input bit rdy);
    bit want_fetch;
    bit dreq;
    dreq = 1'b0;
`ifdef FETCH_DEBUG_PORT_EN
    dreq = dbg_req;
`endif
    want_fetch = !m_halt_st && (!m_valid || rdy);
    return dreq && (!want_fetch || m_wait == 3);
  endfunction

  function automatic logic [3:0] model_rom_addr(input bit rdy);
    logic [3:0] a;
    a = m_pc;
`ifdef FETCH_DEBUG_PORT_EN
    if (model_dbg_owns(rdy)) a = dbg_addr;
`endif
    return a;
  endfunction

  // One rising edge of the specified behaviour.
  task automatic model_step(input bit r, input bit rdy, input bit rd, input logic [3:0] rp, input bit h);
    bit want_fetch;
    bit dbg_won;
    bit dreq;
    logic [3:0] daddr;
    dreq  = 1'b0;
    daddr = 4'd0;
`ifdef FETCH_DEBUG_PORT_EN
    dreq  = dbg_req;
    daddr = dbg_addr;
`endif
    if (r) begin
      model_reset();
      return;
    end
    want_fetch = !m_halt_st && (!m_valid || rdy);
    dbg_won    = model_dbg_owns(rdy);
    m_dbg_ack  = dbg_won;
    if (dbg_won) m_dbg_data = rom[daddr];
    m_wait = (dreq && !dbg_won) ? m_wait + 1 : 0;
    if (m_halt_st) begin
      if (m_valid && rdy) m_valid = 1'b0;
    end else begin
      if (rd) begin
        m_pc    = rp;
        m_valid = 1'b0;
      end else if (want_fetch && !dbg_won && !h) begin
        m_inst  = rom[m_pc];
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_pc    = 4'((int'(m_pc) + 1) % 16);
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      if (h) m_halt_st = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, clock it, and compare all outputs with the model.
  task automatic do_cycle(input bit r, input bit rdy, input bit rd, input logic [3:0] rp, input bit h);
    bit acc;
    rst            = r;
    inst_ready     = rdy;
    redirect_valid = rd;
    redirect_pc    = rp;
    halt           = h;
    #1;
    if (!r) check("rom_addr", 32'(rom_addr), 32'(model_rom_addr(rdy)));
    acc = !r && m_valid && rdy;
    @(posedge clk);
    if (acc) $display("[TB] t=%0t accept inst=%h pc=%0d", $time, m_inst, m_ipc);
    model_step(r, rdy, rd, rp, h);
    #1;
    check("inst_valid", 32'(inst_valid), 32'(m_valid));
    check("inst", 32'(inst), 32'(m_inst));
    check("inst_pc", 32'(inst_pc), 32'(m_ipc));
    check("halted", 32'(halted), 32'(m_halt_st && !m_valid));
`ifdef FETCH_DEBUG_PORT_EN
    check("dbg_ack", 32'(dbg_ack), 32'(m_dbg_ack));
    check("dbg_data", 32'(dbg_data), 32'(m_dbg_data));
    if (m_dbg_ack) dbg_req = 1'b0;
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'(i * 16'h0911 + 16'h0042);
    rom[0]  = 16'h1E07;
    rom[1]  = 16'hBE01;
    rom[2]  = 16'hCA00;
    rom[3]  = 16'h8100;
    rom[10] = 16'hF200;
    rom[11] = 16'h8A00;
    model_reset();

    // reset
    do_cycle(1, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);

    // streaming start
    do_cycle(0, 1, 0, 0, 0);
    check("c1_inst", 32'(inst), 32'h1E07);
    check("c1_pc", 32'(inst_pc), 32'd0);
    do_cycle(0, 1, 0, 0, 0);
    check("c2_inst", 32'(inst), 32'hBE01);

    // decode stall
    for (int k = 0; k < 3; k++) begin
      do_cycle(0, 0, 0, 0, 0);
      check("stall_inst", 32'(inst), 32'hBE01);
      check("stall_rom_addr", 32'(rom_addr), 32'd2);
    end
    do_cycle(0, 1, 0, 0, 0);
    check("release_inst", 32'(inst), 32'hCA00);

    // redirect flushes a held instruction
    do_cycle(0, 0, 1, 4'd10, 0);
    check("redir_bubble", 32'(inst_valid), 32'd0);
    do_cycle(0, 0, 0, 0, 0);
    check("redir_inst", 32'(inst), 32'hF200);
    check("redir_pc", 32'(inst_pc), 32'd10);
    for (int k = 0; k < 6; k++) do_cycle(0, 1, 0, 0, 0);
    check("wrap_pc", 32'(inst_pc), 32'd0);
    check("wrap_inst", 32'(inst), 32'h1E07);

    // halt with a held instruction
    do_cycle(0, 0, 0, 0, 1);
    check("halt_held", 32'(inst_valid), 32'd1);
    check("halt_not_done", 32'(halted), 32'd0);
    do_cycle(0, 1, 0, 0, 0);
    check("halt_done", 32'(halted), 32'd1);
    do_cycle(0, 1, 1, 4'd5, 0);
    do_cycle(0, 1, 1, 4'd5, 0);
    check("halt_ignore_redir", 32'(inst_valid), 32'd0);
    do_cycle(1, 0, 0, 0, 0);
    do_cycle(0, 1, 0, 0, 0);
    check("rerun_inst", 32'(inst), 32'h1E07);

`ifdef FETCH_DEBUG_PORT_EN
    begin
      int waited;
      bit got;
      waited   = 0;
      got      = 1'b0;
      dbg_addr = 4'd11;
      dbg_req  = 1'b1;
      for (int k = 0; k < 10 && !got; k++) begin
        do_cycle(0, 1, 0, 0, 0);
        waited++;
        if (dbg_ack) got = 1'b1;
      end
      check("dbg_wait", 32'(waited), 32'd4);
      check("dbg_data11", 32'(dbg_data), 32'h8A00);
      check("dbg_bubble", 32'(inst_valid), 32'd0);
      do_cycle(0, 0, 0, 0, 0);
      dbg_addr = 4'd3;
      dbg_req  = 1'b1;
      do_cycle(0, 0, 0, 0, 0);
      check("dbg_fast_ack", 32'(dbg_ack), 32'd1);
      check("dbg_data3", 32'(dbg_data), 32'h8100);
      do_cycle(0, 0, 0, 0, 0);
      check("dbg_pulse", 32'(dbg_ack), 32'd0);
    end
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit r, rdy, rd, h;
      logic [3:0] rp;
      r   = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 7) == 0);
      rp  = 4'($urandom);
      h   = ($urandom_range(0, 39) == 0);
`ifdef FETCH_DEBUG_PORT_EN
      if (!dbg_req && $urandom_range(0, 5) == 0) begin
        dbg_addr = 4'($urandom);
        dbg_req  = 1'b1;
      end
`endif
      do_cycle(r, rdy, rd, rp, h);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
